// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   DEF_XLEN / DEF_NREG / DEF_NRD / DEF_NWR : default geometry
//   calcAw()    : address width for a given register count (at least 1)
//   sliceBase() : bit offset of port 'port' inside a flattened bus whose
//                 per-port field is 'width' bits wide
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_XLEN = 64;
   localparam int DEF_NREG = 32;
   localparam int DEF_NRD  = 2;
   localparam int DEF_NWR  = 2;

   function automatic int calcAw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sliceBase(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// ---------------------------------------------------------------------------
// regfile_pend_ctr
// Outstanding-write counter for one architectural register.
// Next value is cnt + inc - dec, floored at zero (an untracked writer is
// legal) and held at the maximum when an issue would push it past the top.
// Ports:
//   clock   : sole clock
//   reset   : synchronous, active-high
//   inc_i   : an instruction targeting this register issues this cycle
//   dec_i   : number of write ports retiring a write to this register
//   cnt_o   : current outstanding-write count
//   ovf_o   : combinational pulse, an issue was dropped at the ceiling
// ---------------------------------------------------------------------------
module regfile_pend_ctr
   import regfile_pkg::*;
#(
   parameter int PEND_W = 2,
   parameter int DEC_W  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inc_i,
   input  logic [DEC_W-1:0]  dec_i,
   output logic [PEND_W-1:0] cnt_o,
   output logic              ovf_o
);

   localparam int CNT_MAX = (1 << PEND_W) - 1;

   logic [PEND_W-1:0] cnt_q;
   logic [PEND_W-1:0] cnt_d;
   int                upI;
   int                netI;

   // Work in signed int so the floor and ceiling cases fall out of a single
   // subtraction; only an increment can ever exceed the maximum, so that
   // case holds the old value and flags the lost issue.
   always_comb begin
      cnt_d = cnt_q;
      ovf_o = 1'b0;
      upI   = int'(cnt_q) + (inc_i ? 1 : 0);
      netI  = upI - int'(dec_i);
      if (netI < 0) begin
         cnt_d = '0;
      end else if (netI > CNT_MAX) begin
         cnt_d = cnt_q;
         ovf_o = 1'b1;
      end else begin
         cnt_d = PEND_W'(netI);
      end
   end

   // Counter register; reset wins over any same-cycle issue or write.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with a per-register pending-write
// scoreboard. x0 reads as zero, ignores writes and is never pending.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   rdAddr       : NRD read addresses, port k at [k*AW +: AW]
//   rdData       : NRD read data words (combinational)
//   rdReady      : per read port, register has no unresolved pending write
//   wrEn/wrAddr/wrData : NWR write ports; highest index wins on conflict
//   issueEn/issueAddr  : destination of the instruction issued this cycle
//   pendErr      : sticky flag, an issue was dropped at counter saturation
// ---------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREG   = DEF_NREG,
   parameter int NRD    = DEF_NRD,
   parameter int NWR    = DEF_NWR,
   parameter int BYPASS = 1,
   parameter int PEND_W = 2,
   parameter int AW     = calcAw(NREG)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rdAddr,
   output logic [NRD*XLEN-1:0] rdData,
   output logic [NRD-1:0]      rdReady,
   input  logic [NWR-1:0]      wrEn,
   input  logic [NWR*AW-1:0]   wrAddr,
   input  logic [NWR*XLEN-1:0] wrData,
   input  logic                issueEn,
   input  logic [AW-1:0]       issueAddr,
   output logic                pendErr
);

   localparam int DEC_W = $clog2(NWR + 1);

   logic [XLEN-1:0]   regs_q [NREG];
   logic [XLEN-1:0]   regs_d [NREG];
   logic [PEND_W-1:0] cnt    [NREG];
   logic [DEC_W-1:0]  dec    [NREG];
   logic [XLEN-1:0]   wrWin  [NREG];
   logic [NREG-1:0]   wrHit;
   logic [NREG-1:0]   inc;
   logic [NREG-1:0]   ovf;
   logic              pendErr_q;
   logic              pendErr_d;
   logic [AW-1:0]     ra;

   // Decode the write and issue ports per register. Scanning write ports in
   // ascending order lets the highest-index port overwrite the winning data,
   // which is the required conflict priority. x0 is never hit or counted.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         dec[r]   = '0;
         wrHit[r] = 1'b0;
         wrWin[r] = '0;
         inc[r]   = 1'b0;
         if (r != 0) begin
            inc[r] = issueEn && (issueAddr == AW'(r));
            for (int w = 0; w < NWR; w++) begin
               if (wrEn[w] && (wrAddr[sliceBase(w, AW) +: AW] == AW'(r))) begin
                  dec[r]   = dec[r] + DEC_W'(1);
                  wrHit[r] = 1'b1;
                  wrWin[r] = wrData[sliceBase(w, XLEN) +: XLEN];
               end
            end
         end
      end
   end

   // Next array contents: only registers hit by an enabled write change.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         regs_d[r] = wrHit[r] ? wrWin[r] : regs_q[r];
      end
   end

   // Storage array; a reset cycle discards any writes presented with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   // x0 has no counter, so it always looks idle and never overflows.
   assign cnt[0] = '0;
   assign ovf[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : gen_pend
      regfile_pend_ctr #(
         .PEND_W (PEND_W),
         .DEC_W  (DEC_W)
      ) u_ctr (
         .clock  (clock),
         .reset  (reset),
         .inc_i  (inc[g]),
         .dec_i  (dec[g]),
         .cnt_o  (cnt[g]),
         .ovf_o  (ovf[g])
      );
   end

   // Sticky error: any dropped issue latches the flag until the next reset.
   always_comb begin
      pendErr_d = pendErr_q | (|ovf);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pendErr_q <= 1'b0;
      end else begin
         pendErr_q <= pendErr_d;
      end
   end

   assign pendErr = pendErr_q;

   // Read ports. With bypass, writes retiring this cycle count against the
   // pending counter, so a register whose last producer writes now reads as
   // ready with the new data. A same-cycle issue is deliberately ignored
   // here; it only shows up once the counter has advanced.
   always_comb begin
      rdData  = '0;
      rdReady = '0;
      ra      = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = rdAddr[sliceBase(k, AW) +: AW];
         if ((ra == '0) || (int'(ra) >= NREG)) begin
            rdData[sliceBase(k, XLEN) +: XLEN] = '0;
            rdReady[k] = 1'b1;
         end else begin
            if ((BYPASS != 0) && wrHit[ra]) begin
               rdData[sliceBase(k, XLEN) +: XLEN] = wrWin[ra];
            end else begin
               rdData[sliceBase(k, XLEN) +: XLEN] = regs_q[ra];
            end
            rdReady[k] = (cnt[ra] == '0) ||
                         ((BYPASS != 0) && (int'(dec[ra]) >= int'(cnt[ra])));
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share every input: dutB has
// write-to-read bypass, dutN does not, so each vector shows both behaviours.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

   logic         clock;
   logic         reset;
   logic [9:0]   rdAddr;
   logic [127:0] rdDataB;
   logic [127:0] rdDataN;
   logic [1:0]   rdReadyB;
   logic [1:0]   rdReadyN;
   logic [1:0]   wrEn;
   logic [9:0]   wrAddr;
   logic [127:0] wrData;
   logic         issueEn;
   logic [4:0]   issueAddr;
   logic         pendErrB;
   logic         pendErrN;

   int checkCount;
   int passCount;

   regfile_mp #(
      .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1), .PEND_W(2)
   ) dutB (
      .clock     (clock),
      .reset     (reset),
      .rdAddr    (rdAddr),
      .rdData    (rdDataB),
      .rdReady   (rdReadyB),
      .wrEn      (wrEn),
      .wrAddr    (wrAddr),
      .wrData    (wrData),
      .issueEn   (issueEn),
      .issueAddr (issueAddr),
      .pendErr   (pendErrB)
   );

   regfile_mp #(
      .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0), .PEND_W(2)
   ) dutN (
      .clock     (clock),
      .reset     (reset),
      .rdAddr    (rdAddr),
      .rdData    (rdDataN),
      .rdReady   (rdReadyN),
      .wrEn      (wrEn),
      .wrAddr    (wrAddr),
      .wrData    (wrData),
      .issueEn   (issueEn),
      .issueAddr (issueAddr),
      .pendErr   (pendErrN)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive both write ports and the issue port for the coming cycle.
   task automatic applyStimulus(input logic [1:0] we,
                                input logic [4:0] a0, input logic [63:0] d0,
                                input logic [4:0] a1, input logic [63:0] d1,
                                input logic ie, input logic [4:0] ia);
      wrEn      = we;
      wrAddr    = {a1, a0};
      wrData    = {d1, d0};
      issueEn   = ie;
      issueAddr = ia;
   endtask

   task automatic idle();
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0);
   endtask

   task automatic setReads(input logic [4:0] a0, input logic [4:0] a1);
      rdAddr = {a1, a0};
   endtask

   // Advance past the next rising edge; inputs change 1 time unit later.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Let combinational outputs settle before sampling mid-cycle.
   task automatic settle();
      #2;
   endtask

   function automatic logic [63:0] port(input logic [127:0] bus, input int k);
      return bus[k*64 +: 64];
   endfunction

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      rdAddr     = '0;
      idle();
      stepCycle();
      stepCycle();
      reset = 1'b0;
      settle();

      // Reset state on every register, both ports.
      checkOutput("pendErrB reset", 64'(pendErrB), 64'h0);
      checkOutput("pendErrN reset", 64'(pendErrN), 64'h0);
      for (int r = 1; r < 32; r++) begin
         setReads(5'(r), 5'(32 - r));
         settle();
         checkOutput("reset dataB p0", port(rdDataB, 0), 64'h0);
         checkOutput("reset dataB p1", port(rdDataB, 1), 64'h0);
         checkOutput("reset dataN p0", port(rdDataN, 0), 64'h0);
         checkOutput("reset readyB", 64'(rdReadyB), 64'h3);
         checkOutput("reset readyN", 64'(rdReadyN), 64'h3);
      end

      // x0 ignores writes, even on the bypass path.
      stepCycle();
      applyStimulus(2'b01, 5'd0, 64'hDEAD, 5'd0, 64'h0, 1'b0, 5'd0);
      setReads(5'd0, 5'd0);
      settle();
      checkOutput("x0 bypass dataB", port(rdDataB, 0), 64'h0);
      checkOutput("x0 readyB", 64'(rdReadyB), 64'h3);
      stepCycle();
      idle();
      settle();
      checkOutput("x0 after dataB", port(rdDataB, 0), 64'h0);
      checkOutput("x0 after dataN", port(rdDataN, 0), 64'h0);

      // Write conflict on x5: port 1 wins.
      stepCycle();
      applyStimulus(2'b11, 5'd5, 64'h11, 5'd5, 64'h22, 1'b0, 5'd0);
      setReads(5'd5, 5'd0);
      settle();
      checkOutput("x5 bypass dataB", port(rdDataB, 0), 64'h22);
      checkOutput("x5 same-cycle dataN", port(rdDataN, 0), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x5 dataB", port(rdDataB, 0), 64'h22);
      checkOutput("x5 dataN", port(rdDataN, 0), 64'h22);
      checkOutput("x5 readyB", 64'(rdReadyB), 64'h3);

      // Issue x7; the same-cycle issue must not lower ready.
      stepCycle();
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd7);
      setReads(5'd7, 5'd0);
      settle();
      checkOutput("x7 issue-cycle readyB", 64'(rdReadyB[0]), 64'h1);
      checkOutput("x7 issue-cycle readyN", 64'(rdReadyN[0]), 64'h1);
      stepCycle();
      idle();
      settle();
      checkOutput("x7 +1 readyB", 64'(rdReadyB[0]), 64'h0);
      checkOutput("x7 +1 readyN", 64'(rdReadyN[0]), 64'h0);
      stepCycle();
      settle();
      checkOutput("x7 +2 readyB", 64'(rdReadyB[0]), 64'h0);
      stepCycle();
      applyStimulus(2'b01, 5'd7, 64'h77, 5'd0, 64'h0, 1'b0, 5'd0);
      settle();
      checkOutput("x7 +3 readyB", 64'(rdReadyB[0]), 64'h1);
      checkOutput("x7 +3 dataB", port(rdDataB, 0), 64'h77);
      checkOutput("x7 +3 readyN", 64'(rdReadyN[0]), 64'h0);
      checkOutput("x7 +3 dataN", port(rdDataN, 0), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x7 +4 readyB", 64'(rdReadyB[0]), 64'h1);
      checkOutput("x7 +4 readyN", 64'(rdReadyN[0]), 64'h1);
      checkOutput("x7 +4 dataN", port(rdDataN, 0), 64'h77);

      // Two issues to x9 need two writes to clear.
      setReads(5'd0, 5'd9);
      stepCycle();
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9);
      stepCycle();
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9);
      stepCycle();
      applyStimulus(2'b01, 5'd9, 64'h91, 5'd0, 64'h0, 1'b0, 5'd0);
      settle();
      checkOutput("x9 cnt2 write readyB", 64'(rdReadyB[1]), 64'h0);
      checkOutput("x9 cnt2 write readyN", 64'(rdReadyN[1]), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x9 cnt1 readyB", 64'(rdReadyB[1]), 64'h0);
      checkOutput("x9 cnt1 dataN", port(rdDataN, 1), 64'h91);
      stepCycle();
      applyStimulus(2'b10, 5'd0, 64'h0, 5'd9, 64'h92, 1'b0, 5'd0);
      settle();
      checkOutput("x9 last write readyB", 64'(rdReadyB[1]), 64'h1);
      checkOutput("x9 last write dataB", port(rdDataB, 1), 64'h92);
      checkOutput("x9 last write readyN", 64'(rdReadyN[1]), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x9 cnt0 readyN", 64'(rdReadyN[1]), 64'h1);

      // Issue and write together while cnt=1: count stays 1.
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9);
      stepCycle();
      applyStimulus(2'b01, 5'd9, 64'h93, 5'd0, 64'h0, 1'b1, 5'd9);
      settle();
      checkOutput("x9 iss+wr readyB", 64'(rdReadyB[1]), 64'h1);
      checkOutput("x9 iss+wr readyN", 64'(rdReadyN[1]), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x9 still pending B", 64'(rdReadyB[1]), 64'h0);
      checkOutput("x9 still pending N", 64'(rdReadyN[1]), 64'h0);
      checkOutput("x9 iss+wr dataN", port(rdDataN, 1), 64'h93);

      // Second issue (cnt=2), then both ports retire x9 in one cycle.
      applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9);
      stepCycle();
      applyStimulus(2'b11, 5'd9, 64'hA1, 5'd9, 64'hA2, 1'b0, 5'd0);
      settle();
      checkOutput("x9 dual write readyB", 64'(rdReadyB[1]), 64'h1);
      checkOutput("x9 dual write dataB", port(rdDataB, 1), 64'hA2);
      stepCycle();
      idle();
      settle();
      checkOutput("x9 dual done readyN", 64'(rdReadyN[1]), 64'h1);
      checkOutput("x9 dual done dataN", port(rdDataN, 1), 64'hA2);

      // Untracked write to a non-pending register: floor at 0, no error.
      applyStimulus(2'b01, 5'd11, 64'hBB, 5'd0, 64'h0, 1'b0, 5'd0);
      stepCycle();
      idle();
      setReads(5'd11, 5'd0);
      settle();
      checkOutput("x11 untracked readyN", 64'(rdReadyN[0]), 64'h1);
      checkOutput("x11 untracked pendErrN", 64'(pendErrN), 64'h0);
      checkOutput("x11 dataN", port(rdDataN, 0), 64'hBB);

      // Saturate x3: three issues fit, the fourth sets pendErr.
      applyStimulus(2'b01, 5'd3, 64'h33, 5'd0, 64'h0, 1'b0, 5'd0);
      setReads(5'd3, 5'd5);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         applyStimulus(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd3);
      end
      stepCycle();
      settle();
      checkOutput("x3 cnt3 pendErrB", 64'(pendErrB), 64'h0);
      checkOutput("x3 cnt3 readyB", 64'(rdReadyB[0]), 64'h0);
      stepCycle();
      idle();
      settle();
      checkOutput("x3 ovf pendErrB", 64'(pendErrB), 64'h1);
      checkOutput("x3 ovf pendErrN", 64'(pendErrN), 64'h1);
      checkOutput("x3 ovf readyN", 64'(rdReadyN[0]), 64'h0);

      // Two writes leave cnt=1 if it held at 3 rather than wrapping.
      applyStimulus(2'b01, 5'd3, 64'h34, 5'd0, 64'h0, 1'b0, 5'd0);
      stepCycle();
      applyStimulus(2'b01, 5'd3, 64'h35, 5'd0, 64'h0, 1'b0, 5'd0);
      stepCycle();
      idle();
      settle();
      checkOutput("x3 held readyN", 64'(rdReadyN[0]), 64'h0);
      checkOutput("x3 held dataN", port(rdDataN, 0), 64'h35);
      checkOutput("pendErr sticky", 64'(pendErrN), 64'h1);

      // Reset in the middle of activity discards that cycle's traffic.
      reset = 1'b1;
      applyStimulus(2'b11, 5'd3, 64'h55, 5'd5, 64'h66, 1'b1, 5'd3);
      stepCycle();
      reset = 1'b0;
      idle();
      settle();
      checkOutput("post-reset pendErrB", 64'(pendErrB), 64'h0);
      checkOutput("post-reset pendErrN", 64'(pendErrN), 64'h0);
      checkOutput("post-reset readyB", 64'(rdReadyB), 64'h3);
      checkOutput("post-reset readyN", 64'(rdReadyN), 64'h3);
      checkOutput("post-reset x3 dataN", port(rdDataN, 0), 64'h0);
      checkOutput("post-reset x5 dataB", port(rdDataB, 1), 64'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
